// File: rtl/delta_module_if.sv
// Handshake bundle for delta_module: dcda/dadz input stream and delta/out_idx result stream.
interface delta_module_if #(
  parameter int IDX_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      dcda;
  logic [15:0]      dadz;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      delta;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output in_valid, dcda, dadz, out_ready,
    input  in_ready, out_valid, delta, out_idx
  );

  modport slave (
    input  in_valid, dcda, dadz, out_ready,
    output in_ready, out_valid, delta, out_idx
  );
endinterface

// File: rtl/delta_module.sv
// Backprop delta stage: delta = dcda * dadz (Q6.10) for N_NEURONS pairs per training step.
// Define DELTA_SATURATE_EN to clamp overflowing products instead of wrapping.
module delta_module #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    step,
  input  logic [3:0]    controller,
  delta_module_if.slave bus,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [IDX_W-1:0]   cnt_reg;
  logic               out_valid_reg;
  logic [15:0]        delta_reg;
  logic [IDX_W-1:0]   idx_reg;

  logic               accept;
  logic               last;
  logic signed [31:0] product;
  logic [15:0]        result;
  logic               unused_frac;

  assign product     = $signed(bus.dcda) * $signed(bus.dadz);
  assign unused_frac = ^product[9:0];

`ifdef DELTA_SATURATE_EN
  logic overflow;
  // Product fits Q6.10 only when bits [31:25] are all copies of the sign bit
  assign overflow = (product[31:25] != {7{product[31]}});
  assign result   = overflow ? (product[31] ? 16'h8000 : 16'h7FFF) : product[25:10];
`else
  logic unused_high;
  assign unused_high = ^product[31:26];
  assign result      = product[25:10];
`endif

  // One-entry output register: accept only when the slot is free or being drained
  assign bus.in_ready  = (state_reg == RUN) && (!out_valid_reg || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = (cnt_reg == IDX_W'(N_NEURONS - 1));
  assign bus.out_valid = out_valid_reg;
  assign bus.delta     = delta_reg;
  assign bus.out_idx   = idx_reg;
  assign done          = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (step != 4'd0 && controller == 4'd7) state_next = RUN;
      RUN:     if (accept && last) state_next = DRAIN;
      DRAIN:   if (out_valid_reg && bus.out_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      delta_reg     <= '0;
      idx_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg       <= last ? '0 : cnt_reg + IDX_W'(1);
        out_valid_reg <= 1'b1;
        delta_reg     <= result;
        idx_reg       <= cnt_reg;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_delta_module.sv
// Directed bench for delta_module: single-step flow, back-pressure ordering, async reset in DRAIN.
module tb_delta_module;

  logic       clk;
  logic       rst;
  logic [3:0] step;
  logic [3:0] controller;
  logic       done;

  int n_cmp = 0;
  int n_mis = 0;

  delta_module_if #(.IDX_W(2)) bus ();

  delta_module #(.N_NEURONS(4), .IDX_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .controller (controller),
    .bus        (bus.slave),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DELTA_SATURATE_EN
  localparam logic [15:0] BIG_EXP = 16'h7FFF;
`else
  localparam logic [15:0] BIG_EXP = 16'hA000;
`endif

  logic [15:0] t1_a [4] = '{16'h0400, 16'hFC00, 16'h5000, 16'h0C00};
  logic [15:0] t1_b [4] = '{16'h0100, 16'h0100, 16'h0800, 16'hFE00};
  logic [15:0] t1_e [4] = '{16'h0100, 16'hFF00, BIG_EXP,  16'hFA00};

  logic [15:0] t2_a [4] = '{16'hFFFF, 16'h0800, 16'h0200, 16'h7FFF};
  logic [15:0] t2_b [4] = '{16'h0200, 16'h0600, 16'h0200, 16'h0400};
  logic [15:0] t2_e [4] = '{16'hFFFF, 16'h0C00, 16'h0100, 16'h7FFF};

  logic [15:0] t3_b [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0C00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic set_pair(input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.dcda     = a;
    bus.dadz     = b;
  endtask

  // Call at a negedge; returns at the next negedge with the FSM in RUN
  task automatic start_seq(input logic [3:0] s);
    step       = s;
    controller = 4'd7;
    @(negedge clk);
    step       = 4'd0;
    controller = 4'd3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic hs;
    logic acc;
    int   k;
    int   got;

    rst          = 1'b1;
    step         = 4'd0;
    controller   = 4'd0;
    bus.in_valid = 1'b0;
    bus.dcda     = '0;
    bus.dadz     = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_delta",     32'(bus.delta),     0);
    check("rst_out_idx",   32'(bus.out_idx),   0);
    check("rst_done",      32'(done),          0);
    check("rst_in_ready",  32'(bus.in_ready),  0);
    rst = 1'b0;
    #1 check("idle_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);

    // Single step, out_ready held high
    bus.out_ready = 1'b1;
    start_seq(4'd1);
    #1 check("run_in_ready", 32'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      set_pair(t1_a[i], t1_b[i]);
      @(negedge clk);
      check($sformatf("s1_delta%0d", i), 32'(bus.delta),     32'(t1_e[i]));
      check($sformatf("s1_idx%0d", i),   32'(bus.out_idx),   i);
      check($sformatf("s1_valid%0d", i), 32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    #1 check("s1_drain_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    check("s1_done",       32'(done),          1);
    check("s1_valid_clr",  32'(bus.out_valid), 0);
    @(negedge clk);
    check("s1_done_pulse", 32'(done),          0);
    check("s1_idle_ready", 32'(bus.in_ready),  0);

    // Back-pressure: first result stalls, remaining pairs wait
    bus.out_ready = 1'b0;
    start_seq(4'd2);
    set_pair(t2_a[0], t2_b[0]);
    @(negedge clk);
    set_pair(t2_a[1], t2_b[1]);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_in_ready", 32'(bus.in_ready),  0);
      check("stall_valid",    32'(bus.out_valid), 1);
      check("stall_delta",    32'(bus.delta),     32'(t2_e[0]));
      check("stall_idx",      32'(bus.out_idx),   0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    k   = 1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      #1;
      hs  = bus.out_valid && bus.out_ready;
      acc = bus.in_valid && bus.in_ready;
      if (hs) begin
        check($sformatf("b2b_delta%0d", got), 32'(bus.delta),   32'(t2_e[got]));
        check($sformatf("b2b_idx%0d", got),   32'(bus.out_idx), got);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (k < 4) set_pair(t2_a[k], t2_b[k]);
        else bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_count", got, 4);
    check("b2b_done",  32'(done),          1);
    check("b2b_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("b2b_done_pulse", 32'(done),         0);
    check("b2b_idle_ready", 32'(bus.in_ready), 0);

    // Asynchronous reset while DRAIN holds a result
    bus.out_ready = 1'b1;
    start_seq(4'd3);
    for (int i = 0; i < 4; i++) begin
      set_pair(16'h0400, t3_b[i]);
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    #1;
    check("drain_valid",    32'(bus.out_valid), 1);
    check("drain_idx",      32'(bus.out_idx),   3);
    check("drain_delta",    32'(bus.delta),     32'h0C00);
    check("drain_in_ready", 32'(bus.in_ready),  0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid",    32'(bus.out_valid), 0);
    check("arst_delta",    32'(bus.delta),     0);
    check("arst_idx",      32'(bus.out_idx),   0);
    check("arst_done",     32'(done),          0);
    check("arst_in_ready", 32'(bus.in_ready),  0);
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_done",  32'(done),          0);
      check("post_rst_valid", 32'(bus.out_valid), 0);
      check("post_rst_ready", 32'(bus.in_ready),  0);
    end
    start_seq(4'd1);
    #1 check("restart_in_ready", 32'(bus.in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
